// File: rtl/wb_queue_pkg.sv
// Shared core definitions for the write-back queue.
//   CORE_XLEN  : register data width
//   REG_W      : register-address width
//   CORE_DEPTH : default number of pending-write entries
//   wb_entry_t : one pending register write {rd, wd}
package wb_queue_pkg;

  localparam int CORE_XLEN  = 32;
  localparam int REG_W      = 5;
  localparam int CORE_DEPTH = 4;

  typedef struct packed {
    logic [REG_W-1:0]     rd;
    logic [CORE_XLEN-1:0] wd;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue_fwd.sv
// Youngest-match forwarding search over the pending-write ring.
// Purely combinational; one instance per register-file read port.
//   entries : ring storage (all slots, valid or not)
//   head    : index of the oldest pending entry
//   count   : number of pending entries
//   rs      : lookup register address (0 never hits)
//   hit     : some pending entry targets rs
//   data    : data of the youngest such entry, 0 on miss
module wb_queue_fwd
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = CORE_DEPTH,
  parameter int XLEN  = CORE_XLEN
) (
  input  wb_entry_t                 entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]  head,
  input  logic [$clog2(DEPTH):0]    count,
  input  logic [REG_W-1:0]          rs,
  output logic                      hit,
  output logic [XLEN-1:0]           data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] idx;

  // Walk from oldest to youngest; a later match overrides an earlier one,
  // so the value left behind belongs to the entry closest to the tail.
  // The index wraps naturally because DEPTH is a power of two.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (rs != '0) && (entries[idx].rd == rs)) begin
        hit  = 1'b1;
        data = entries[idx].wd;
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: buffers register writes in order and drains them to the
// register file when permitted, with two forwarding lookup ports that see
// the youngest pending value of a register.
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : producer handshake; in_rd/in_wd carry the write
//   drain_en          : allows the head entry to retire this cycle
//   we/rd/wd          : register-file write port (head entry)
//   rs1/rs2           : forwarding lookup addresses
//   fwdN_hit/data     : forwarding results
//   count/empty/full  : occupancy
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = CORE_DEPTH,
  // Must match the core data width carried by wb_entry_t.
  parameter int XLEN  = CORE_XLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REG_W-1:0]         in_rd,
  input  logic [XLEN-1:0]          in_wd,
  input  logic                     drain_en,
  output logic                     we,
  output logic [REG_W-1:0]         rd,
  output logic [XLEN-1:0]          wd,
  input  logic [REG_W-1:0]         rs1,
  input  logic [REG_W-1:0]         rs2,
  output logic                     fwd1_hit,
  output logic [XLEN-1:0]          fwd1_data,
  output logic                     fwd2_hit,
  output logic [XLEN-1:0]          fwd2_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] cnt;
  wb_entry_t        mem [DEPTH];

  logic push_fire;
  logic push_en;
  logic pop;

  // Occupancy and handshake
  assign empty    = (cnt == '0);
  assign full     = (cnt == CNT_W'(DEPTH));
  assign count    = cnt;
  assign in_ready = !full;

  // A write to x0 completes the handshake but is never stored.
  assign push_fire = in_valid && in_ready;
  assign push_en   = push_fire && (in_rd != '0);

  // Register-file port is driven straight from the head slot; the address
  // and data are forced to zero when nothing is pending so stale storage
  // never shows up on the port.
  assign we  = !empty && drain_en;
  assign pop = we;
  assign rd  = empty ? '0 : mem[head].rd;
  assign wd  = empty ? '0 : mem[head].wd;

  // Control state: pointers and occupancy. Both pointers may advance on the
  // same edge, which leaves the occupancy unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push_en) tail <= tail + PTR_W'(1);
      if (pop)     head <= head + PTR_W'(1);
      if (push_en && !pop)      cnt <= cnt + CNT_W'(1);
      else if (!push_en && pop) cnt <= cnt - CNT_W'(1);
    end
  end

  // Entry storage is not reset: validity is defined by head/count alone.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[tail] <= '{rd: in_rd, wd: in_wd};
    end
  end

  // Lookups see only registered state, so a write being pushed this cycle
  // is invisible and one being popped this cycle is still visible.
  wb_queue_fwd #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_fwd1 (
    .entries (mem),
    .head    (head),
    .count   (cnt),
    .rs      (rs1),
    .hit     (fwd1_hit),
    .data    (fwd1_data)
  );

  wb_queue_fwd #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_fwd2 (
    .entries (mem),
    .head    (head),
    .count   (cnt),
    .rs      (rs2),
    .hit     (fwd2_hit),
    .data    (fwd2_data)
  );

endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue (DEPTH=4, XLEN=32).
module tb_wb_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_wd;
  logic        drain_en;
  logic        we;
  logic [4:0]  rd;
  logic [31:0] wd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        fwd1_hit;
  logic [31:0] fwd1_data;
  logic        fwd2_hit;
  logic [31:0] fwd2_data;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  int total = 0;
  int bad   = 0;

  wb_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rd     (in_rd),
    .in_wd     (in_wd),
    .drain_en  (drain_en),
    .we        (we),
    .rd        (rd),
    .wd        (wd),
    .rs1       (rs1),
    .rs2       (rs2),
    .fwd1_hit  (fwd1_hit),
    .fwd1_data (fwd1_data),
    .fwd2_hit  (fwd2_hit),
    .fwd2_data (fwd2_data),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_wd = '0;
    drain_en = 1'b1; rs1 = '0; rs2 = '0;
    step(); step();
    total++; if (empty !== 1'b1)    begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
    total++; if (full !== 1'b0)     begin bad++; $display("FAIL reset_full got=%b want=0", full); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    total++; if (we !== 1'b0)       begin bad++; $display("FAIL reset_we got=%b want=0", we); end
    total++; if (rd !== 5'd0 || wd !== 32'd0) begin bad++; $display("FAIL reset_rdwd got=%0d/%h want=0/0", rd, wd); end
    total++; if (count !== 3'd0)    begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (fwd1_hit !== 1'b0 || fwd2_hit !== 1'b0) begin bad++; $display("FAIL reset_fwd got=%b%b want=00", fwd1_hit, fwd2_hit); end
    rst = 1'b0;
  endtask

  // Also exercises acceptance on the first edge after reset release.
  task automatic test_single();
    drain_en = 1'b1; in_valid = 1'b1; in_rd = 5'd5; in_wd = 32'hDEADBEEF;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", in_ready); end
    step();
    in_valid = 1'b0;
    #1;
    total++; if (we !== 1'b1 || rd !== 5'd5 || wd !== 32'hDEADBEEF) begin bad++; $display("FAIL single_write got=%b/%0d/%h want=1/5/deadbeef", we, rd, wd); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d want=1", count); end
    step();
    total++; if (empty !== 1'b1 || we !== 1'b0 || rd !== 5'd0) begin bad++; $display("FAIL single_empty got=%b/%b/%0d want=1/0/0", empty, we, rd); end
  endtask

  task automatic test_full();
    int k;
    bit accept;
    logic [4:0] exp_rd;
    drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_rd = 5'(i); in_wd = 32'(i * 256);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_ready%0d got=%b want=1", i, in_ready); end
      step();
    end
    in_rd = 5'd5; in_wd = 32'h500;
    #1;
    total++; if (full !== 1'b1 || count !== 3'd4) begin bad++; $display("FAIL full_flag got=%b/%0d want=1/4", full, count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready5 got=%b want=0", in_ready); end
    total++; if (we !== 1'b0) begin bad++; $display("FAIL full_hold_we got=%b want=0", we); end
    step();
    total++; if (count !== 3'd4) begin bad++; $display("FAIL full_stall_count got=%0d want=4", count); end
    drain_en = 1'b1;
    #1;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      if (we) begin
        exp_rd = 5'(k + 1);
        total++; if (rd !== exp_rd || wd !== 32'(k * 256 + 256)) begin bad++; $display("FAIL full_order%0d got=%0d/%h want=%0d/%h", k, rd, wd, exp_rd, 32'(k * 256 + 256)); end
        k++;
      end
      accept = in_valid && in_ready;
      step();
      if (accept) in_valid = 1'b0;
      #1;
    end
    total++; if (k !== 5) begin bad++; $display("FAIL full_write_count got=%0d want=5", k); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL full_drained got=%b want=1", empty); end
  endtask

  task automatic test_fwd();
    drain_en = 1'b0; rs1 = 5'd7; rs2 = 5'd0;
    in_valid = 1'b1; in_rd = 5'd7; in_wd = 32'h11;
    #1;
    total++; if (fwd1_hit !== 1'b0) begin bad++; $display("FAIL fwd_push_invisible got=%b want=0", fwd1_hit); end
    step();
    in_wd = 32'h22;
    #1;
    total++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h11) begin bad++; $display("FAIL fwd_first got=%b/%h want=1/11", fwd1_hit, fwd1_data); end
    step();
    in_valid = 1'b0;
    #1;
    total++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h22) begin bad++; $display("FAIL fwd_youngest got=%b/%h want=1/22", fwd1_hit, fwd1_data); end
    total++; if (fwd2_hit !== 1'b0 || fwd2_data !== 32'h0) begin bad++; $display("FAIL fwd_rs0 got=%b/%h want=0/0", fwd2_hit, fwd2_data); end
    rs2 = 5'd3;
    #1;
    total++; if (fwd2_hit !== 1'b0 || fwd2_data !== 32'h0) begin bad++; $display("FAIL fwd_miss got=%b/%h want=0/0", fwd2_hit, fwd2_data); end
    drain_en = 1'b1;
    #1;
    total++; if (we !== 1'b1 || rd !== 5'd7 || wd !== 32'h11) begin bad++; $display("FAIL fwd_drain1 got=%b/%0d/%h want=1/7/11", we, rd, wd); end
    total++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h22) begin bad++; $display("FAIL fwd_during_pop got=%b/%h want=1/22", fwd1_hit, fwd1_data); end
    step();
    total++; if (we !== 1'b1 || rd !== 5'd7 || wd !== 32'h22) begin bad++; $display("FAIL fwd_drain2 got=%b/%0d/%h want=1/7/22", we, rd, wd); end
    total++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h22) begin bad++; $display("FAIL fwd_last_popping got=%b/%h want=1/22", fwd1_hit, fwd1_data); end
    step();
    total++; if (fwd1_hit !== 1'b0 || fwd1_data !== 32'h0 || empty !== 1'b1) begin bad++; $display("FAIL fwd_after_drain got=%b/%h/%b want=0/0/1", fwd1_hit, fwd1_data, empty); end
    rs1 = 5'd0; rs2 = 5'd0;
  endtask

  task automatic test_zero_rd();
    drain_en = 1'b1; in_valid = 1'b1; in_rd = 5'd0; in_wd = 32'hFFFFFFFF;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL zero_ready got=%b want=1", in_ready); end
    step();
    in_valid = 1'b0;
    #1;
    total++; if (count !== 3'd0 || empty !== 1'b1) begin bad++; $display("FAIL zero_count got=%0d/%b want=0/1", count, empty); end
    total++; if (we !== 1'b0) begin bad++; $display("FAIL zero_we got=%b want=0", we); end
    step();
    total++; if (we !== 1'b0) begin bad++; $display("FAIL zero_we_later got=%b want=0", we); end
  endtask

  task automatic test_back_to_back();
    drain_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_rd = 5'(10 + i); in_wd = 32'(32'hA000 + i);
      #1;
      if (i > 0) begin
        total++; if (count !== 3'd1) begin bad++; $display("FAIL stream_count%0d got=%0d want=1", i, count); end
        total++; if (we !== 1'b1 || rd !== 5'(9 + i) || wd !== 32'(32'hA000 + i - 1)) begin bad++; $display("FAIL stream_order%0d got=%b/%0d/%h want=1/%0d/%h", i, we, rd, wd, 9 + i, 32'hA000 + i - 1); end
      end
      step();
    end
    in_valid = 1'b0;
    #1;
    total++; if (count !== 3'd1 || we !== 1'b1 || rd !== 5'd19 || wd !== 32'hA009) begin bad++; $display("FAIL stream_last got=%0d/%b/%0d/%h want=1/1/19/a009", count, we, rd, wd); end
    step();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL stream_empty got=%b want=1", empty); end
  endtask

  task automatic test_async_reset();
    int wes;
    drain_en = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_rd = 5'(i); in_wd = 32'(i);
      #1;
      step();
    end
    in_valid = 1'b0;
    #1;
    total++; if (count !== 3'd3) begin bad++; $display("FAIL areset_pending got=%0d want=3", count); end
    #2;
    drain_en = 1'b1;
    rst = 1'b1;
    #1;
    total++; if (empty !== 1'b1 || we !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL areset_immediate got=%b/%b/%0d want=1/0/0", empty, we, count); end
    step();
    rst = 1'b0;
    wes = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (we) wes++;
      step();
    end
    total++; if (wes !== 0) begin bad++; $display("FAIL areset_no_write got=%0d want=0", wes); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL areset_empty got=%b want=1", empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_fwd();
    test_zero_rd();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of pending-write entries (power of two, >=2).
REQ-002 SHALL have parameter XLEN, default 32, meaning the data width.
REQ-003 SHALL have ports as listed below, clock and reset first. The design has one clock, and reset is asynchronous and active-high.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer offers a register write.
- in_ready  output  1  queue accepts the offered write this cycle.
- in_rd  input  5  destination register of offered write.
- in_wd  input  XLEN  data of offered write.
- drain_en  input  1  permits the head entry to be written to the register file this cycle.
- we  output  1  register-file write enable.
- rd  output  5  register-file write address.
- wd  output  XLEN  register-file write data.
- rs1  input  5  forwarding lookup address 1.
- rs2  input  5  forwarding lookup address 2.
- fwd1_hit  output  1  a pending entry matches rs1.
- fwd1_data  output  XLEN  data of the youngest pending entry matching rs1.
- fwd2_hit  output  1  a pending entry matches rs2.
- fwd2_data  output  XLEN  data of the youngest pending entry matching rs2.
- count  output  $clog2(DEPTH)+1  number of pending entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.

Function
REQ-004 SHALL set in_ready = !full; a push occurs on a rising edge where in_valid && in_ready.
REQ-005 SHALL discard a push with in_rd == 0 (handshake completes; nothing is enqueued; count is unchanged).
REQ-006 SHALL drive we = !empty && drain_en, with rd/wd equal to the head entry, combinationally from state.
REQ-007 SHALL pop the head on the same rising edge where we == 1.
- Minimum latency is one cycle: an entry pushed into an empty queue at edge N is written at edge N+1.
REQ-008 SHALL keep rd/wd at 0 when empty.
REQ-009 SHALL handle a simultaneous push and pop by leaving count unchanged and advancing both pointers. This is legal at any fill level except full, where in_ready is 0.
REQ-010 SHALL wrap the head and tail pointers modulo DEPTH, with no lost or duplicated entries across wrap.
REQ-011 SHALL, when drain_en is 0, hold all entries, keep we at 0, and still accept pushes until full.
REQ-012 SHALL assert fwdN_hit when any valid entry has rd == rsN and rsN != 0.
REQ-013 SHALL make fwdN_data the youngest (closest to tail) matching entry's data, and 0 on miss.
REQ-014 SHALL compute forwarding combinationally from current state only. An entry being pushed this cycle is not visible to lookups; an entry being popped this cycle is still visible.
REQ-015 SHALL preserve program order: writes reach the register file in push order, including repeated writes to the same rd.

Reset
REQ-016 SHALL, while rst is high, clear the head pointer, tail pointer and count, and drop all pending entries.
- Outputs during reset: we=0, rd=0, wd=0, empty=1, full=0, in_ready=1, fwd hits=0.
REQ-017 SHALL, when rst asserts mid-operation, discard pending entries without writing them; entry data storage need not be cleared.
REQ-018 SHALL accept a push on the first rising edge after rst deasserts.

Structure
REQ-019 SHALL take XLEN, the register-address width (5), the default DEPTH and the entry struct {rd, wd} from the shared core package.
REQ-020 SHALL place the youngest-match forwarding search in one combinational sub-module, wb_queue_fwd, instantiated once per lookup port.

Verification
REQ-021 SHALL cover: push (rd=5, wd=0xDEADBEEF) with drain_en=1 into an empty queue -> next cycle we=1, rd=5, wd=0xDEADBEEF; empty the following cycle.
REQ-022 SHALL cover: drain_en=0, pushes to rd=1..5 -> full after 4 pushes, in_ready=0 on the 5th push (rd=5 held); drain_en=1 -> writes rd=1,2,3,4,5 in order.
REQ-023 SHALL cover: pushes rd=7/wd=0x11 then rd=7/wd=0x22 with drain_en=0, rs1=7 -> fwd1_hit=1, fwd1_data=0x22; rs2=0 -> fwd2_hit=0.
REQ-024 SHALL cover: push in_rd=0, wd=0xFFFFFFFF -> in_ready=1, count stays 0, we never asserts.
REQ-025 SHALL cover: a continuous push/pop stream of 10 entries with drain_en=1 -> count constant at 1, correct order across pointer wrap.
REQ-026 SHALL cover: rst asserted asynchronously with 3 entries pending -> immediately empty=1, we=0; no pending entry is written afterwards.
